// File: rtl/sensor_cond.sv
// sensor_cond: per-bit sensor debounce, per-approach request latching,
// wait-time aging and oldest-approach selection for the light sequencer.
// Optional feature macro: SENSOR_DEBOUNCE_EN (defined = debounce filter,
// undefined = plain 1-edge register of the raw sensors).
module sensor_cond #(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sensor_light,
   input  logic [3:0] clr,
   output logic [7:0] sensor_filt,
   output logic [3:0] req,
   output logic       any_req,
   output logic [1:0] oldest_dir
);

   localparam int unsigned NS = 8;   // sensor bits
   localparam int unsigned ND = 4;   // approaches
   localparam int unsigned WW = 8;   // wait counter width
   localparam logic [WW-1:0] WAIT_MAX = '1;

   // Reject out-of-range debounce lengths at elaboration
   if (DEB_CYCLES < 2 || DEB_CYCLES > 15) begin : g_deb_range
      $error("sensor_cond: DEB_CYCLES must be in 2..15");
   end

   logic [WW-1:0] wait_cnt [ND];
   logic [3:0]    src;

`ifdef SENSOR_DEBOUNCE_EN
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [CW-1:0] cnt [NS];

   // Debounce: a bit must disagree for DEB_CYCLES consecutive edges to flip
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sensor_filt <= '0;
         for (int i = 0; i < NS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NS; i++) begin
            if (sensor_light[i] == sensor_filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               sensor_filt[i] <= sensor_light[i];
               cnt[i]         <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end
`else
   // No filtering: raw sensors registered once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sensor_filt <= '0;
      else     sensor_filt <= sensor_light;
   end
`endif

   // Approach sources: N=filt[6], S=filt[4], E=filt[5], W=filt[7]
   assign src = {sensor_filt[6], sensor_filt[4], sensor_filt[5], sensor_filt[7]};

   // Request latch and saturating wait counter; clear wins over set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req <= '0;
         for (int d = 0; d < ND; d++) wait_cnt[d] <= '0;
      end else begin
         for (int d = 0; d < ND; d++) begin
            if (clr[d])      req[d] <= 1'b0;
            else if (src[d]) req[d] <= 1'b1;

            if (clr[d])
               wait_cnt[d] <= '0;
            else if (req[d] && wait_cnt[d] != WAIT_MAX)
               wait_cnt[d] <= wait_cnt[d] + WW'(1);
         end
      end
   end

   assign any_req = |req;

   // Oldest pending approach; scanning N first with strict '>' gives N>S>E>W on ties
   always_comb begin
      logic [1:0]    best;
      logic [WW-1:0] best_w;
      logic          found;
      best   = 2'd3;
      best_w = '0;
      found  = 1'b0;
      for (int d = ND - 1; d >= 0; d--) begin
         if (req[d] && (!found || wait_cnt[d] > best_w)) begin
            best   = 2'(d);
            best_w = wait_cnt[d];
            found  = 1'b1;
         end
      end
      oldest_dir = best;
   end

endmodule

// File: tb/tb_sensor_cond.sv
// Self-checking bench for sensor_cond: a behavioural model pushes the
// expected state per edge into a queue; scenario tasks pop and compare.
module tb_sensor_cond;

   localparam int unsigned DEB = 4;
`ifdef SENSOR_DEBOUNCE_EN
   localparam int unsigned LAT = DEB;
`else
   localparam int unsigned LAT = 1;
`endif

   typedef struct packed {
      logic [7:0]  filt;
      logic [3:0]  req;
      logic        any;
      logic [1:0]  oldest;
      logic [31:0] waits;
   } snap_t;

   localparam snap_t RESET_SNAP = '{filt: 8'h00, req: 4'h0, any: 1'b0, oldest: 2'd3, waits: 32'h0};

   logic       clk;
   logic       rst;
   logic [7:0] sensor_light;
   logic [3:0] clr;
   logic [7:0] sensor_filt;
   logic [3:0] req;
   logic       any_req;
   logic [1:0] oldest_dir;

   int n_pass;
   int n_total;

   logic [7:0] m_filt;
   int         m_cnt [8];
   logic [3:0] m_req;
   int         m_wait [4];
   snap_t      exp_q [$];
   snap_t      exp_s;
   snap_t      got;

   sensor_cond #(.DEB_CYCLES(DEB)) dut (
      .clk          (clk),
      .rst          (rst),
      .sensor_light (sensor_light),
      .clr          (clr),
      .sensor_filt  (sensor_filt),
      .req          (req),
      .any_req      (any_req),
      .oldest_dir   (oldest_dir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic snap_t observe();
      snap_t s;
      s.filt   = sensor_filt;
      s.req    = req;
      s.any    = any_req;
      s.oldest = oldest_dir;
      s.waits  = {dut.wait_cnt[3], dut.wait_cnt[2], dut.wait_cnt[1], dut.wait_cnt[0]};
      return s;
   endfunction

   function automatic snap_t model_snap();
      snap_t s;
      int best;
      int bw;
      best = 3;
      bw   = -1;
      for (int d = 3; d >= 0; d--) begin
         if (m_req[d] && m_wait[d] > bw) begin
            best = d;
            bw   = m_wait[d];
         end
      end
      s.filt   = m_filt;
      s.req    = m_req;
      s.any    = |m_req;
      s.oldest = 2'(best);
      s.waits  = {8'(m_wait[3]), 8'(m_wait[2]), 8'(m_wait[1]), 8'(m_wait[0])};
      return s;
   endfunction

   task automatic model_reset();
      m_filt = '0;
      m_req  = '0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      for (int d = 0; d < 4; d++) m_wait[d] = 0;
   endtask

   // Advance the model with the current inputs, queue the expectation, clock the DUT
   task automatic tick();
      logic [7:0] nf;
      logic [3:0] nr;
      logic [3:0] s;
      int nc [8];
      int nw [4];
      s  = {m_filt[6], m_filt[4], m_filt[5], m_filt[7]};
      nf = m_filt;
      for (int i = 0; i < 8; i++) begin
`ifdef SENSOR_DEBOUNCE_EN
         if (sensor_light[i] == m_filt[i]) nc[i] = 0;
         else if (m_cnt[i] == int'(DEB) - 1) begin
            nf[i] = sensor_light[i];
            nc[i] = 0;
         end else nc[i] = m_cnt[i] + 1;
`else
         nf[i] = sensor_light[i];
         nc[i] = 0;
`endif
      end
      for (int d = 0; d < 4; d++) begin
         nr[d] = clr[d] ? 1'b0 : (s[d] ? 1'b1 : m_req[d]);
         nw[d] = clr[d] ? 0 : ((m_req[d] && m_wait[d] < 255) ? m_wait[d] + 1 : m_wait[d]);
      end
      m_filt = nf;
      m_req  = nr;
      for (int i = 0; i < 8; i++) m_cnt[i] = nc[i];
      for (int d = 0; d < 4; d++) m_wait[d] = nw[d];
      exp_q.push_back(model_snap());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sensor_light = '0;
      clr = '0;
      model_reset();
      #3;
      got = observe();
      n_total++;
      if (got !== RESET_SNAP) $display("FAIL reset_state: got %h required %h", got, RESET_SNAP);
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_clear_all();
      sensor_light = '0;
      clr = 4'hF;
      for (int k = 0; k < int'(LAT) + 1; k++) begin
         tick();
         exp_s = exp_q.pop_front();
         got = observe();
         n_total++;
         if (got !== exp_s) $display("FAIL clear_all edge %0d: got %h required %h", k, got, exp_s);
         else n_pass++;
      end
      clr = '0;
   endtask

   task automatic test_debounce_rise();
      sensor_light = 8'h40;
      for (int k = 1; k <= int'(LAT) + 1; k++) begin
         tick();
         exp_s = exp_q.pop_front();
         got = observe();
         n_total++;
         if (got !== exp_s) $display("FAIL rise_model edge %0d: got %h required %h", k, got, exp_s);
         else n_pass++;
         n_total++;
         if (sensor_filt[6] !== (k >= int'(LAT)))
            $display("FAIL rise_filt6 edge %0d: got %b required %b", k, sensor_filt[6], (k >= int'(LAT)));
         else n_pass++;
         n_total++;
         if (req[3] !== (k >= int'(LAT) + 1))
            $display("FAIL rise_reqN edge %0d: got %b required %b", k, req[3], (k >= int'(LAT) + 1));
         else n_pass++;
      end
   endtask

`ifdef SENSOR_DEBOUNCE_EN
   task automatic test_glitch();
      for (int k = 0; k < 9; k++) begin
         sensor_light = (k < int'(LAT) - 1) ? 8'h20 : 8'h00;
         tick();
         exp_s = exp_q.pop_front();
         got = observe();
         n_total++;
         if (got !== exp_s) $display("FAIL glitch_model edge %0d: got %h required %h", k, got, exp_s);
         else n_pass++;
         n_total++;
         if (sensor_filt[5] !== 1'b0 || req[1] !== 1'b0)
            $display("FAIL glitch_blocked edge %0d: got filt5=%b reqE=%b required 0 0", k, sensor_filt[5], req[1]);
         else n_pass++;
      end
   endtask
`else
   task automatic test_follow();
      logic v;
      for (int k = 0; k < 10; k++) begin
         v = (k % 2) == 0;
         sensor_light = {3'b000, v, 4'b0000};
         tick();
         exp_s = exp_q.pop_front();
         got = observe();
         n_total++;
         if (got !== exp_s) $display("FAIL follow_model edge %0d: got %h required %h", k, got, exp_s);
         else n_pass++;
         n_total++;
         if (sensor_filt[4] !== v) $display("FAIL follow_filt4 edge %0d: got %b required %b", k, sensor_filt[4], v);
         else n_pass++;
      end
   endtask
`endif

   task automatic test_saturate();
      sensor_light = 8'h10;
      for (int k = 0; k < 300; k++) begin
         tick();
         exp_s = exp_q.pop_front();
         got = observe();
         n_total++;
         if (got !== exp_s) $display("FAIL saturate_model edge %0d: got %h required %h", k, got, exp_s);
         else n_pass++;
      end
      n_total++;
      if (dut.wait_cnt[2] !== 8'd255) $display("FAIL saturate_waitS: got %0d required 255", dut.wait_cnt[2]);
      else n_pass++;
      tick();
      exp_s = exp_q.pop_front();
      n_total++;
      if (dut.wait_cnt[2] !== 8'd255 || req[2] !== 1'b1)
         $display("FAIL saturate_hold: got wait=%0d req=%b required 255 1", dut.wait_cnt[2], req[2]);
      else n_pass++;
   endtask

   task automatic test_oldest();
      sensor_light = 8'h60;
      for (int k = 0; k < int'(LAT) + 11; k++) begin
         tick();
         exp_s = exp_q.pop_front();
         got = observe();
         n_total++;
         if (got !== exp_s) $display("FAIL oldest_model edge %0d: got %h required %h", k, got, exp_s);
         else n_pass++;
      end
      n_total++;
      if (oldest_dir !== 2'd3) $display("FAIL oldest_tie: got %0d required 3", oldest_dir);
      else n_pass++;
      clr = 4'b1000;
      tick();
      exp_s = exp_q.pop_front();
      got = observe();
      n_total++;
      if (got !== exp_s) $display("FAIL oldest_clr_model: got %h required %h", got, exp_s);
      else n_pass++;
      n_total++;
      if (req[3] !== 1'b0 || dut.wait_cnt[3] !== 8'd0 || oldest_dir !== 2'd1)
         $display("FAIL oldest_clrN: got reqN=%b waitN=%0d oldest=%0d required 0 0 1", req[3], dut.wait_cnt[3], oldest_dir);
      else n_pass++;
      clr = 4'b0000;
      tick();
      exp_s = exp_q.pop_front();
      got = observe();
      n_total++;
      if (got !== exp_s) $display("FAIL oldest_reset_model: got %h required %h", got, exp_s);
      else n_pass++;
      n_total++;
      if (req[3] !== 1'b1 || oldest_dir !== 2'd1)
         $display("FAIL oldest_reassert: got reqN=%b oldest=%0d required 1 1", req[3], oldest_dir);
      else n_pass++;
      // All four approaches pending, then clear S and W together
      sensor_light = 8'hF0;
      for (int k = 0; k < int'(LAT) + 3; k++) begin
         tick();
         exp_s = exp_q.pop_front();
         got = observe();
         n_total++;
         if (got !== exp_s) $display("FAIL all_pending edge %0d: got %h required %h", k, got, exp_s);
         else n_pass++;
      end
      clr = 4'b0101;
      tick();
      exp_s = exp_q.pop_front();
      got = observe();
      n_total++;
      if (got !== exp_s) $display("FAIL multi_clr_model: got %h required %h", got, exp_s);
      else n_pass++;
      n_total++;
      if (req !== 4'b1010 || dut.wait_cnt[2] !== 8'd0 || dut.wait_cnt[0] !== 8'd0)
         $display("FAIL multi_clr: got req=%b waitS=%0d waitW=%0d required 1010 0 0", req, dut.wait_cnt[2], dut.wait_cnt[0]);
      else n_pass++;
      clr = 4'b0000;
   endtask

   task automatic test_reset_mid();
      sensor_light = 8'h40;
      for (int k = 0; k < 2; k++) begin
         tick();
         exp_s = exp_q.pop_front();
         got = observe();
         n_total++;
         if (got !== exp_s) $display("FAIL pre_reset edge %0d: got %h required %h", k, got, exp_s);
         else n_pass++;
      end
      rst = 1'b1;
      #2;
      got = observe();
      n_total++;
      if (got !== RESET_SNAP) $display("FAIL reset_mid_state: got %h required %h", got, RESET_SNAP);
      else n_pass++;
      model_reset();
      rst = 1'b0;
      for (int k = 1; k <= int'(LAT); k++) begin
         tick();
         exp_s = exp_q.pop_front();
         got = observe();
         n_total++;
         if (got !== exp_s) $display("FAIL post_reset_model edge %0d: got %h required %h", k, got, exp_s);
         else n_pass++;
         n_total++;
         if (sensor_filt[6] !== (k == int'(LAT)))
            $display("FAIL post_reset_filt6 edge %0d: got %b required %b", k, sensor_filt[6], (k == int'(LAT)));
         else n_pass++;
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_debounce_rise();
      test_clear_all();
`ifdef SENSOR_DEBOUNCE_EN
      test_glitch();
`else
      test_follow();
`endif
      test_clear_all();
      test_saturate();
      test_clear_all();
      test_oldest();
      test_clear_all();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
